keypad_scan_debounce: RTL

Upstream entry stage for the half-precision adder board. Scans a 4x4 matrix keypad, synchronises and debounces the row inputs, and decodes each accepted press into a 4-bit hex digit. Each accepted digit is shifted into a 16-bit entry word. The entry word feeds the operand-capture registers and the default display path.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/row_sync.sv | 23 ++
 rtl/keypad_scan_debounce.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, key map and row priority encoder for the keypad entry stage.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    // Indexed [row][column]; '*' decodes to E and '#' to F.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Index of the lowest-numbered low bit; also used to decode the column drive.
    function automatic logic [1:0] row_to_index(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchroniser for the asynchronous keypad rows; idles at all-ones.
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            meta <= '1;
            dout <= '1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad scanner: column scan, press/release debounce, hex decode and
// a 16-bit shifting entry word.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  SCAN     | rotating the active column every SCAN_DIV cycles
//  DEBOUNCE | column frozen, waiting for the latched row pattern to hold
//  HELD     | digit accepted, waiting for a stable release
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [3:0]  Row,
    output logic [3:0]  Col,
    output logic [15:0] Out,
    output logic [3:0]  Value,
    output logic        Trig
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

    logic [3:0]       rs;
    kp_state_t        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] stab_q, stab_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       pat_q, pat_d;
    logic [15:0]      out_q, out_d;
    logic [3:0]       value_q, value_d;
    logic             trig_q, trig_d;
    logic [3:0]       digit;

    row_sync #(
        .WIDTH (4)
    ) u_row_sync (
        .Clock (Clock),
        .Reset (Reset),
        .din   (Row),
        .dout  (rs)
    );

    // The column register doubles as the latched column while frozen.
    assign digit = KEYMAP[row_to_index(pat_q)][row_to_index(col_q)];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= SCAN;
            div_q   <= '0;
            stab_q  <= '0;
            col_q   <= 4'b1110;
            pat_q   <= 4'hF;
            out_q   <= 16'h0000;
            value_q <= 4'h0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            stab_q  <= stab_d;
            col_q   <= col_d;
            pat_q   <= pat_d;
            out_q   <= out_d;
            value_q <= value_d;
            trig_q  <= trig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        stab_d  = stab_q;
        col_d   = col_q;
        pat_d   = pat_q;
        out_d   = out_q;
        value_d = value_q;
        trig_d  = 1'b0;

        case (state_q)
            SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (rs != 4'hF) begin
                        pat_d   = rs;
                        stab_d  = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (rs != pat_q) begin
                    state_d = SCAN;
                    col_d   = {col_q[2:0], col_q[3]};
                    div_d   = '0;
                    stab_d  = '0;
                end else if (stab_q == DEB_LAST) begin
                    trig_d  = 1'b1;
                    value_d = digit;
                    out_d   = {out_q[11:0], digit};
                    stab_d  = '0;
                    state_d = HELD;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end

            HELD: begin
                // Only a run of all-high rows counts toward release.
                if (rs != 4'hF) begin
                    stab_d = '0;
                end else if (stab_q == DEB_LAST) begin
                    state_d = SCAN;
                    col_d   = {col_q[2:0], col_q[3]};
                    div_d   = '0;
                    stab_d  = '0;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end

            default: begin
                state_d = SCAN;
                div_d   = '0;
                stab_d  = '0;
            end
        endcase
    end

    assign Col   = col_q;
    assign Out   = out_q;
    assign Value = value_q;
    assign Trig  = trig_q;

endmodule
